p_acc_pow2: RTL and testbench
=============================

// Module: p_acc_pow2
// PURPOSE
//  Streaming accumulator directly upstream of p_div_pow2: sums exactly 2^SHIFT
//  signed samples, then presents the full-precision sum with a valid/ready
//  handshake. p_div_pow2 with the same SHIFT consumes the sum to form the mean
//  (pooling/averaging in the perceptron datapath). Handles INT and FXP identically.
// PARAMETERS
//  SHIFT   2           log2 of samples per frame; N = 1<<SHIFT; 0 <= SHIFT <= 8
//  I_CONF  `DEF_DCONF  input data config (dtype, prec)
//  O_CONF  derived     prec = I_CONF.prec+SHIFT, dtype = I_CONF.dtype; feeds divider I_CONF
// PORTS
//  clk        in   1                  clock, rising edge
//  reset_     in   1                  asynchronous reset, active-low
//  flush      in   1                  sync clear of partial frame / pending result
//  in_valid   in   1                  sample valid
//  in_ready   out  1                  block accepts sample
//  in         in   I_CONF.prec        signed sample
//  out_valid  out  1                  frame sum valid
//  out_ready  in   1                  downstream accepts sum
//  out        out  I_CONF.prec+SHIFT  signed frame sum
//  cnt        out  SHIFT+1            samples accepted in current frame
// BEHAVIOUR
//  Reset (reset_=0, async): state=ACC, cnt=0, acc=0, out=0, out_valid=0.
//   in_ready goes 1 once reset_ deasserts (combinational from state).
//  States: ACC (collecting), OUT (holding result).
//   ACC: in_ready=1, out_valid=0. Accept = in_valid&in_ready.
//     accept, cnt<N-1: acc <= (cnt==0 ? sext(in) : acc+sext(in)); cnt++.
//     accept, cnt==N-1: out <= acc+sext(in) (sext(in) if N=1); cnt<=0; ->OUT.
//     no accept: hold acc, cnt.
//   OUT: in_ready=0, out_valid=1; out, acc stable until handshake.
//     out_valid&out_ready: ->ACC, out_valid=0 next cycle; out keeps last value.
//  Latency: out_valid rises the cycle after the N-th accept.
//  No overlap: frame throughput = N accept cycles + >=1 OUT cycle.
//  Arithmetic: sign-extend in to I_CONF.prec+SHIFT; sum of N values at
//   that width never overflows; no rounding, no saturation; wrap impossible.
//  FXP: fraction point unchanged; downstream divider restores scale.
//  dtype BOOL/FP: in_ready=1, samples discarded, out_valid=0, out=0.
//  flush=1 (sync, highest priority): next cycle state=ACC, cnt=0, acc=0,
//   out_valid=0; a sample offered with flush is dropped; a pending
//   result is discarded even if out_ready=1 that cycle.
//  in_valid with in_ready=0 (OUT): not accepted; upstream holds it.
//  Reset mid-frame: partial sum lost, no out_valid spike.
//  cnt output mirrors internal counter (0..N-1).
// TESTING
//  T1 SHIFT=2, prec=8, out_ready=1: in 10,20,30,40 back-to-back -> out_valid
//     one cycle after 4th accept, out=100 (10 bits), in_ready=0 for 1 cycle.
//  T2 Sign/extremes: 4x -128 -> out=-512 (10'h200); 4x 127 -> out=508.
//  T3 Backpressure: frame done, out_ready=0 for 5 cycles -> out_valid=1,
//     out stable, in_ready=0, in_valid ignored; out_ready=1 -> next cycle ACC.
//  T4 Gaps: in_valid toggling 1,0,0,1,0,1,1 with values 1,2,3,4 -> out=10,
//     cnt steps 0,1,1,1,2,2,3,0.
//  T5 Flush after 2 samples (5,6), then 1,1,1,1 -> out=4; flush during
//     OUT with out_ready=1 -> out_valid=0 next cycle, no sum consumed.
//  T6 reset_ low mid-frame then 3 frames back-to-back, SHIFT=0 and SHIFT=3
//     -> each out equals sum vs reference model; out_valid never glitches.

Source files
------------

// File: rtl/p_acc_pow2.sv
// p_acc_pow2: sums 2^SHIFT signed samples per frame and hands the full-precision sum downstream over valid/ready
module p_acc_pow2 #(
  parameter int         SHIFT = 2,
  parameter int         PREC  = 8,
  parameter logic [1:0] DTYPE = 2'd0
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PREC-1:0]        in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [PREC+SHIFT-1:0]  out,
  output logic [SHIFT:0]                cnt
);
  localparam int OW = PREC + SHIFT;
  localparam logic [SHIFT:0] LAST = (SHIFT+1)'((1 << SHIFT) - 1);
  localparam bit NUM = DTYPE < 2'd2;
  typedef enum logic {ACC, OUT} state_t;
  state_t state_q, state_d;
  logic signed [OW-1:0] acc, sx, sum;
  logic accept, last;
  assign sx        = OW'(in);
  assign in_ready  = reset_ && (!NUM || state_q == ACC);
  assign out_valid = NUM && state_q == OUT;
  assign accept    = NUM && in_valid && in_ready;
  assign last      = cnt == LAST;
  assign sum       = cnt == '0 ? sx : acc + sx;
  // next state: flush dominates, N-th accept enters OUT, handshake returns to ACC
  always_comb
    state_d = flush ? ACC :
              (state_q == ACC && accept && last) ? OUT :
              (state_q == OUT && out_ready) ? ACC : state_q;
  // state register
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) state_q <= ACC;
    else state_q <= state_d;
  // running sum and sample counter; result latched on the last sample of a frame
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      cnt <= '0;
      acc <= '0;
      out <= '0;
    end else if (flush) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      if (last) begin
        out <= sum;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_p_acc_pow2.sv
// tb_p_acc_pow2: directed and random checks of p_acc_pow2 at SHIFT 2/0/3 plus a non-numeric dtype instance
module tb_p_acc_pow2;
  logic clk = 0, reset_ = 0, flush = 0, in_valid = 0;
  logic signed [7:0] in_d = 0;
  logic [3:0] ordy = 4'hf, ir, ov;
  logic signed [9:0] oa, od;
  logic signed [7:0] ob;
  logic signed [10:0] oc;
  logic [2:0] ca, cd;
  logic [0:0] cb;
  logic [3:0] cc;
  int n_cmp = 0, n_bad = 0;
  int sh[3] = '{2, 0, 3};
  int mcnt[3], msum[3], mout[3];
  bit busy[3];

  always #5 clk = ~clk;

  p_acc_pow2 #(.SHIFT(2), .PREC(8), .DTYPE(2'd0)) u_a (.clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[0]), .in(in_d), .out_valid(ov[0]), .out_ready(ordy[0]), .out(oa), .cnt(ca));
  p_acc_pow2 #(.SHIFT(0), .PREC(8), .DTYPE(2'd1)) u_b (.clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[1]), .in(in_d), .out_valid(ov[1]), .out_ready(ordy[1]), .out(ob), .cnt(cb));
  p_acc_pow2 #(.SHIFT(3), .PREC(8), .DTYPE(2'd0)) u_c (.clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[2]), .in(in_d), .out_valid(ov[2]), .out_ready(ordy[2]), .out(oc), .cnt(cc));
  p_acc_pow2 #(.SHIFT(2), .PREC(8), .DTYPE(2'd3)) u_d (.clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid),
    .in_ready(ir[3]), .in(in_d), .out_valid(ov[3]), .out_ready(ordy[3]), .out(od), .cnt(cd));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check();
    logic signed [31:0] o[3], c[3];
    o[0] = oa; o[1] = ob; o[2] = oc;
    c[0] = {29'b0, ca}; c[1] = {31'b0, cb}; c[2] = {28'b0, cc};
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("out_valid%0d", d), {31'b0, ov[d]}, {31'b0, busy[d]});
      chk($sformatf("in_ready%0d", d), {31'b0, ir[d]}, {31'b0, reset_ && !busy[d]});
      chk($sformatf("out%0d", d), o[d], mout[d]);
      chk($sformatf("cnt%0d", d), c[d], mcnt[d]);
    end
    chk("fp_in_ready", {31'b0, ir[3]}, {31'b0, reset_});
    chk("fp_out_valid", {31'b0, ov[3]}, 0);
    chk("fp_out", od, 0);
    chk("fp_cnt", {29'b0, cd}, 0);
  endtask

  task automatic clear_model(input bit all);
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = 0; msum[d] = 0; busy[d] = 0;
      if (all) mout[d] = 0;
    end
  endtask

  task automatic step(input bit v, input int x, input bit f, input logic [2:0] r);
    in_valid = v; in_d = x[7:0]; flush = f; ordy = {1'b1, r};
    if (!reset_) clear_model(1);
    else if (f) clear_model(0);
    else
      for (int d = 0; d < 3; d++)
        if (busy[d]) begin
          if (r[d]) busy[d] = 0;
        end else if (v) begin
          msum[d] += x;
          mcnt[d]++;
          if (mcnt[d] == (1 << sh[d])) begin
            mout[d] = msum[d]; msum[d] = 0; mcnt[d] = 0; busy[d] = 1;
          end
        end
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic do_reset();
    reset_ = 0;
    clear_model(1);
    #1;
    check();
    step(0, 0, 0, 3'b111);
    step(0, 0, 0, 3'b111);
    reset_ = 1;
  endtask

  initial begin
    int t1[4] = '{10, 20, 30, 40};
    do_reset();
    step(0, 0, 0, 3'b111);
    chk("ready_after_reset", {31'b0, ir[0]}, 1);
    foreach (t1[i]) step(1, t1[i], 0, 3'b111);
    chk("t1_out", oa, 100);
    chk("t1_valid", {31'b0, ov[0]}, 1);
    chk("t1_busy", {31'b0, ir[0]}, 0);
    step(0, 0, 0, 3'b111);
    chk("t1_ready_back", {31'b0, ir[0]}, 1);
    for (int i = 0; i < 4; i++) step(1, -128, 0, 3'b111);
    chk("t2_min", oa, -512);
    step(0, 0, 0, 3'b111);
    for (int i = 0; i < 4; i++) step(1, 127, 0, 3'b111);
    chk("t2_max", oa, 508);
    step(0, 0, 0, 3'b111);
    for (int i = 1; i <= 4; i++) step(1, i, 0, 3'b110);
    for (int i = 0; i < 5; i++) step(1, 99, 0, 3'b110);
    chk("t3_hold_out", oa, 10);
    chk("t3_hold_valid", {31'b0, ov[0]}, 1);
    step(0, 0, 0, 3'b111);
    chk("t3_release", {31'b0, ov[0]}, 0);
    step(1, 1, 0, 3'b111); step(0, 0, 0, 3'b111); step(0, 0, 0, 3'b111);
    step(1, 2, 0, 3'b111); step(0, 0, 0, 3'b111); step(1, 3, 0, 3'b111);
    step(1, 4, 0, 3'b111);
    chk("t4_out", oa, 10);
    step(0, 0, 0, 3'b111);
    step(1, 5, 0, 3'b111); step(1, 6, 0, 3'b111); step(1, 9, 1, 3'b111);
    chk("t5_flush_cnt", {29'b0, ca}, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 3'b111);
    chk("t5_out", oa, 4);
    step(0, 0, 1, 3'b111);
    chk("t5_flush_valid", {31'b0, ov[0]}, 0);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 31) == 0, 3'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
